fb_pingpong_arbiter: RTL and testbench

- Owns the two 1-bit-per-pixel framebuffer BRAMs (bram0/bram1) and assigns them front/back roles.
- Video scanout reads only the front buffer. The waveform plotter writes only the back buffer.
- Before each drawing pass, the block clears the back buffer itself. Buffers swap only on a frame boundary, after the plotter reports the frame complete.
- Sits between hdmiController's pixel/plot logic and the BRAM ports; one instance drives both BRAMs.

---
 rtl/fb_pkg.sv | 16 +
 rtl/fb_port_mux.sv | 71 +++++++
 rtl/fb_pingpong_arbiter.sv | 132 +++++++++++++
 tb/tb_fb_pingpong_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer geometry constants and arbiter state encoding
package fb_pkg;

  localparam int unsigned FB_WIDTH      = 640;
  localparam int unsigned FB_HEIGHT     = 480;
  localparam int unsigned FB_DEPTH      = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned FB_ADDR_WIDTH = 19;

  typedef enum logic [1:0] {
    ST_CLEAR_ALL,
    ST_CLEAR,
    ST_DRAW,
    ST_READY
  } fb_state_e;

endpackage

// File: rtl/fb_port_mux.sv
// rtl/fb_port_mux.sv - registered steering of read and back-buffer traffic onto bram0/bram1
module fb_port_mux
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FB_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  front_sel_i,
  input  logic                  clear_all_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                  back_en_i,
  input  logic [ADDR_WIDTH-1:0] back_addr_i,
  input  logic                  back_wd_i,
  output logic                  we0_o,
  output logic                  we1_o,
  output logic [ADDR_WIDTH-1:0] addr0_o,
  output logic [ADDR_WIDTH-1:0] addr1_o,
  output logic                  wd0_o,
  output logic                  wd1_o
);

  logic [1:0]            we_q, we_d;
  logic [1:0]            wd_q, wd_d;
  logic [ADDR_WIDTH-1:0] addr_q [2];
  logic [ADDR_WIDTH-1:0] addr_d [2];

  // Front address holds between reads; back address holds between writes.
  always_comb begin
    we_d   = '0;
    wd_d   = '0;
    addr_d = addr_q;
    if (clear_all_i) begin
      we_d      = 2'b11;
      addr_d[0] = back_addr_i;
      addr_d[1] = back_addr_i;
    end else begin
      if (rd_en_i) begin
        addr_d[front_sel_i] = rd_addr_i;
      end
      if (back_en_i) begin
        addr_d[~front_sel_i] = back_addr_i;
        we_d[~front_sel_i]   = 1'b1;
        wd_d[~front_sel_i]   = back_wd_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_q      <= '0;
      wd_q      <= '0;
      addr_q[0] <= '0;
      addr_q[1] <= '0;
    end else begin
      we_q      <= we_d;
      wd_q      <= wd_d;
      addr_q[0] <= addr_d[0];
      addr_q[1] <= addr_d[1];
    end
  end

  assign we0_o   = we_q[0];
  assign we1_o   = we_q[1];
  assign wd0_o   = wd_q[0];
  assign wd1_o   = wd_q[1];
  assign addr0_o = addr_q[0];
  assign addr1_o = addr_q[1];

endmodule

// File: rtl/fb_pingpong_arbiter.sv
// rtl/fb_pingpong_arbiter.sv - front/back framebuffer ownership, back-buffer clearing and swap control
module fb_pingpong_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int unsigned DEPTH      = FB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_data,
  output logic                  rd_valid,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_data,
  input  logic                  wr_last,
  output logic                  wr_ack,
  output logic                  WE0,
  output logic                  WE1,
  output logic [ADDR_WIDTH-1:0] addrB0,
  output logic [ADDR_WIDTH-1:0] addrB1,
  output logic                  WD0,
  output logic                  WD1,
  input  logic                  RD0,
  input  logic                  RD1,
  output logic                  front_sel,
  output logic                  swap,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  fb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  front_q, front_d;
  logic                  swap_q, swap_d;
  logic                  busy_q;
  logic [1:0]            rv_q, rsel_q, rzero_q;
  logic                  clearing;
  logic                  wr_in_range;
  logic                  wr_accept;

  assign wr_in_range = 32'(wr_addr) < DEPTH;
  assign wr_accept   = wr_ack && wr_in_range;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    front_d  = front_q;
    swap_d   = 1'b0;
    wr_ack   = 1'b0;
    clearing = 1'b0;
    case (state_q)
      ST_CLEAR_ALL, ST_CLEAR: begin
        clearing = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = ST_DRAW;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_DRAW: begin
        wr_ack = wr_req;
        if (wr_req && wr_last) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (frame_start) begin
          front_d = ~front_q;
          swap_d  = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      default: state_d = ST_CLEAR_ALL;
    endcase
  end

  // busy is registered so it lines up with the clear traffic on the BRAM ports.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CLEAR_ALL;
      cnt_q   <= '0;
      front_q <= 1'b0;
      swap_q  <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= '0;
      rsel_q  <= '0;
      rzero_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      front_q <= front_d;
      swap_q  <= swap_d;
      busy_q  <= clearing;
      rv_q    <= {rv_q[0], rd_req};
      rsel_q  <= {rsel_q[0], front_q};
      rzero_q <= {rzero_q[0], state_q == ST_CLEAR_ALL};
    end
  end

  // Buffer select travels with the read so a swap mid-flight cannot redirect it.
  assign rd_valid  = rv_q[1];
  assign rd_data   = rv_q[1] & ~rzero_q[1] & (rsel_q[1] ? RD1 : RD0);
  assign front_sel = front_q;
  assign swap      = swap_q;
  assign busy      = busy_q;

  fb_port_mux #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_port_mux (
    .clk_i      (clk),
    .rst_n_i    (rst),
    .front_sel_i(front_q),
    .clear_all_i(state_q == ST_CLEAR_ALL),
    .rd_en_i    (rd_req),
    .rd_addr_i  (rd_addr),
    .back_en_i  (clearing | wr_accept),
    .back_addr_i(clearing ? cnt_q : wr_addr),
    .back_wd_i  (~clearing & wr_data),
    .we0_o      (WE0),
    .we1_o      (WE1),
    .addr0_o    (addrB0),
    .addr1_o    (addrB1),
    .wd0_o      (WD0),
    .wd1_o      (WD1)
  );

endmodule

// File: tb/tb_fb_pingpong_arbiter.sv
// tb/tb_fb_pingpong_arbiter.sv - directed scoreboard bench for fb_pingpong_arbiter with DEPTH=16
module tb_fb_pingpong_arbiter;

  localparam int unsigned AW = 19;
  localparam int unsigned DP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_start = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic          wr_data = 1'b0;
  logic          wr_last = 1'b0;
  logic          rd_data, rd_valid, wr_ack;
  logic          WE0, WE1, WD0, WD1, RD0, RD1;
  logic [AW-1:0] addrB0, addrB1;
  logic          front_sel, swap, busy;

  typedef struct {
    int   cyc;
    logic data;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  rd_exp_t mon_e;
  int      cyc = 0;
  int      n_checks = 0;
  int      n_fail = 0;
  int      model_front = 0;
  logic    ref_buf [2][DP];
  logic    mem0 [DP];
  logic    mem1 [DP];

  fb_pingpong_arbiter #(
    .ADDR_WIDTH(AW),
    .DEPTH     (DP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .wr_ack     (wr_ack),
    .WE0        (WE0),
    .WE1        (WE1),
    .addrB0     (addrB0),
    .addrB1     (addrB1),
    .WD0        (WD0),
    .WD1        (WD1),
    .RD0        (RD0),
    .RD1        (RD1),
    .front_sel  (front_sel),
    .swap       (swap),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-first BRAMs, preloaded with ones while reset is held so clearing is observable.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DP; i++) begin
        mem0[i] <= 1'b1;
        mem1[i] <= 1'b1;
      end
      RD0 <= 1'b0;
      RD1 <= 1'b0;
    end else begin
      if (WE0) mem0[addrB0[3:0]] <= WD0;
      if (WE1) mem1[addrB1[3:0]] <= WD1;
      RD0 <= mem0[addrB0[3:0]];
      RD1 <= mem1[addrB1[3:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue_read(input int a);
    rd_req  = 1'b1;
    rd_addr = AW'(a);
    exp_q.push_back('{cyc, ref_buf[model_front][a]});
    tick();
    rd_req = 1'b0;
  endtask

  task automatic zero_buf(input int b);
    for (int i = 0; i < DP; i++) ref_buf[b][i] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(mon_e.data));
        chk("rd_latency", cyc, mon_e.cyc + 2);
      end
    end
  end

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DP; i++) ref_buf[b][i] = 1'b1;

    repeat (3) tick();
    chk("reset_outs", {WE0, WE1, WD0, WD1, rd_valid, rd_data, swap, busy, front_sel, wr_ack}, 0);
    chk("reset_addr", 32'(addrB0 | addrB1), 0);

    // Held out-of-range write: never acked while clearing, acked and dropped once drawing.
    wr_req  = 1'b1;
    wr_addr = AW'(20);
    wr_data = 1'b1;
    rst     = 1'b1;
    #1 chk("ack_clear_all", 32'(wr_ack), 0);
    for (int k = 0; k < DP; k++) begin
      tick();
      chk("clr_all_ports", {WE0, WE1, WD0, WD1, busy}, 5'b11001);
      chk("clr_all_addr0", 32'(addrB0), k);
      chk("clr_all_addr1", 32'(addrB1), k);
      chk("clr_all_ack", 32'(wr_ack), (k == DP - 1) ? 1 : 0);
      if (k == 3) begin
        rd_req  = 1'b1;
        rd_addr = AW'(12);
        exp_q.push_back('{cyc, 1'b0});
      end else begin
        rd_req = 1'b0;
      end
    end
    tick();
    zero_buf(0);
    zero_buf(1);
    chk("oob_dropped", {WE0, WE1, busy, wr_ack}, 4'b0001);

    wr_addr = AW'(5);
    #1 chk("draw_ack", 32'(wr_ack), 1);
    tick();
    ref_buf[1][5] = 1'b1;
    chk("draw_we", {WE0, WE1, WD1}, 3'b011);
    chk("draw_addr1", 32'(addrB1), 5);
    wr_req = 1'b0;
    issue_read(5);
    tick();

    wr_req  = 1'b1;
    wr_addr = AW'(7);
    wr_last = 1'b1;
    #1 chk("last_ack", 32'(wr_ack), 1);
    tick();
    ref_buf[1][7] = 1'b1;
    chk("last_addr1", 32'(addrB1), 7);
    wr_last = 1'b0;
    wr_addr = AW'(2);
    #1 chk("ready_no_ack", 32'(wr_ack), 0);
    wr_req = 1'b0;

    // Read issued in the swap cycle must still come from the old front buffer.
    frame_start = 1'b1;
    issue_read(5);
    frame_start = 1'b0;
    model_front = 1;
    chk("swap_pulse", {front_sel, swap, busy}, 3'b110);
    for (int k = 0; k < DP; k++) begin
      tick();
      chk("clr_ports", {WE0, WE1, WD0, busy}, 4'b1001);
      chk("clr_addr0", 32'(addrB0), k);
      if (k == 0) chk("swap_once", 32'(swap), 0);
    end
    tick();
    zero_buf(0);
    chk("clr_done", 32'(busy), 0);
    issue_read(5);
    issue_read(7);
    issue_read(6);
    tick();

    wr_last = 1'b1;
    tick();
    wr_last     = 1'b0;
    wr_req      = 1'b1;
    wr_addr     = AW'(9);
    frame_start = 1'b1;
    #1 chk("orphan_last_ack", 32'(wr_ack), 1);
    tick();
    ref_buf[0][9] = 1'b1;
    frame_start   = 1'b0;
    chk("fs_in_draw", {front_sel, swap, WE0, WE1}, 4'b1010);
    chk("fs_in_draw_addr", 32'(addrB0), 9);
    wr_addr = AW'(20);
    #1 chk("oob_ack", 32'(wr_ack), 1);
    tick();
    chk("oob_we", {WE0, WE1}, 0);
    wr_req = 1'b0;

    // Reset with a read in flight: nothing may emerge from it.
    rd_req  = 1'b1;
    rd_addr = AW'(9);
    tick();
    rd_req = 1'b0;
    rst    = 1'b0;
    #1 chk("midrst_outs", {WE0, WE1, WD0, WD1, rd_valid, rd_data, swap, busy, front_sel, wr_ack}, 0);
    chk("midrst_addr", 32'(addrB0 | addrB1), 0);
    tick();
    tick();
    rst = 1'b1;
    model_front = 0;
    for (int k = 0; k < DP; k++) begin
      tick();
      chk("reclr_ports", {WE0, WE1, busy}, 3'b111);
      chk("reclr_addr", 32'(addrB0), k);
    end
    tick();
    zero_buf(0);
    zero_buf(1);

    wr_req      = 1'b1;
    wr_addr     = AW'(3);
    wr_data     = 1'b1;
    wr_last     = 1'b1;
    frame_start = 1'b1;
    tick();
    ref_buf[1][3] = 1'b1;
    wr_last     = 1'b0;
    frame_start = 1'b0;
    chk("last_fs_noswap", {front_sel, swap}, 0);
    #1 chk("last_fs_ready", 32'(wr_ack), 0);
    wr_req = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    model_front = 1;
    chk("swap2", {front_sel, swap}, 2'b11);
    repeat (DP + 1) tick();
    zero_buf(0);
    issue_read(3);
    issue_read(4);
    repeat (3) tick();
    chk("rd_pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
